sram_mig_bridge: RTL and testbench

Responder end of the team's SRAM-like 16-bit memory port (`wrap_*` signals). It accepts single word reads and writes from an initiator such as the DDR3 test machine or the CPU. It converts them into MIG native app-interface commands on 128-bit BL8 lines, and keeps a one-line write-through read cache. It sits between the initiator and the MIG core and runs entirely in the MIG `ui_clk` domain.

---
 rtl/sram_mig_pkg.sv | 48 ++++
 rtl/sram_mig_bridge_cache.sv | 64 ++++++
 rtl/sram_mig_bridge.sv | 189 ++++++++++++++++++
 tb/tb_sram_mig_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mig_pkg.sv
// -----------------------------------------------------------------------------
// sram_mig_pkg
// Shared constants for the SRAM-port to MIG app-interface bridge:
//   - FSM state encodings (plain 3-bit constants)
//   - MIG app_cmd opcodes
//   - line / tag / lane geometry for a 128-bit BL8 line of 16-bit words
//   - wdf_mask(): builds the MIG byte mask for a single-word write
// -----------------------------------------------------------------------------
package sram_mig_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_LOOKUP   = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_CMD   = 3'd4;
    localparam logic [2:0] ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    localparam int LINE_W = 128;          // one BL8 burst on a x16 device
    localparam int TAG_W  = 24;           // byte address bits [27:4]
    localparam int LANE_W = 3;            // word select within the line, addr[3:1]
    localparam int WORD_W = 16;
    localparam int MASK_W = LINE_W / 8;

    // MIG mask polarity is 1 = byte NOT written. Only the two bytes of the
    // addressed word can be unmasked, each gated by its byte enable.
    function automatic logic [MASK_W-1:0] wdf_mask(
        input logic [LANE_W-1:0] lane,
        input logic              l,
        input logic              u
    );
        logic [MASK_W-1:0] m;
        m = '1;
        for (int i = 0; i < 8; i++) begin
            if (lane == LANE_W'(i)) begin
                m[2*i]   = ~l;
                m[2*i+1] = ~u;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_mig_bridge_cache.sv
// -----------------------------------------------------------------------------
// sram_line_cache
// One-line write-through read cache holding a single 128-bit MIG line.
// Ports:
//   clk, i_rst        clock / synchronous active-high reset (invalidates)
//   i_tag, i_lane     tag and word lane of the current request
//   i_fill_en/data    load a full line from DDR and mark it valid
//   i_merge_en/data/be
//                     merge enabled bytes of a write into the line (hit only)
//   o_hit             line valid and tag matches
//   o_lane_word       16-bit word of the cached line at i_lane
// -----------------------------------------------------------------------------
module sram_line_cache
    import sram_mig_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_fill_en,
    input  logic [LINE_W-1:0] i_fill_data,
    input  logic              i_merge_en,
    input  logic [WORD_W-1:0] i_merge_data,
    input  logic [1:0]        i_merge_be,
    output logic              o_hit,
    output logic [WORD_W-1:0] o_lane_word
);

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] w_merged;

    assign o_hit       = r_valid && (r_tag == i_tag);
    assign o_lane_word = r_line[{i_lane, 4'b0000} +: WORD_W];

    // Byte gi of the line belongs to word lane gi/2; even bytes take the
    // low half of the write word (L enable), odd bytes the high half (U).
    genvar gi;
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_merge
            logic w_sel;
            assign w_sel = (i_lane == LANE_W'(gi / 2)) && i_merge_be[gi % 2];
            assign w_merged[gi*8 +: 8] = w_sel ? i_merge_data[(gi % 2)*8 +: 8]
                                               : r_line[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_line  <= '0;
        end else if (i_fill_en) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            r_line  <= i_fill_data;
        end else if (i_merge_en && o_hit) begin
            // write-through: no allocate on a miss, merge only on a hit
            r_line  <= w_merged;
        end
    end

endmodule

// File: rtl/sram_mig_bridge.sv
// -----------------------------------------------------------------------------
// sram_mig_bridge
// Responder for the 16-bit SRAM-like wrap_* port. Single-word requests are
// turned into MIG native app-interface commands on 128-bit BL8 lines, with a
// one-line write-through read cache in front. Runs entirely in ui_clk.
// Ports:
//   clk, i_rst, i_calib_done      ui_clk, sync reset, MIG calibration done
//   wrap_Addr/CS/L/U/WE/WR        request (byte address, strobe, byte enables,
//                                 direction, write data)
//   wrap_RD, wrap_ready, wrap_busy
//                                 read data, 1-cycle completion, not accepting
//   app_addr/cmd/en/rdy           MIG command channel
//   app_wdf_data/mask/wren/end/rdy
//                                 MIG write data channel
//   app_rd_data/valid/end         MIG read return
// -----------------------------------------------------------------------------
module sram_mig_bridge
    import sram_mig_pkg::*;
#(
    parameter int ADDR_W = 28
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_calib_done,
    input  logic [31:0]       wrap_Addr,
    input  logic              wrap_CS,
    input  logic              wrap_L,
    input  logic              wrap_U,
    input  logic              wrap_WE,
    input  logic [15:0]       wrap_WR,
    output logic [15:0]       wrap_RD,
    output logic              wrap_ready,
    output logic              wrap_busy,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [127:0]      app_wdf_data,
    output logic [15:0]       app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              app_rd_data_end
);

    state_t            r_state;
    logic [TAG_W-1:0]  r_tag;
    logic [LANE_W-1:0] r_lane;
    logic              r_we;
    logic              r_l;
    logic              r_u;
    logic [WORD_W-1:0] r_wr;
    logic [WORD_W-1:0] r_rd;
    logic              r_cmd_done;   // write command already accepted
    logic              r_data_done;  // write data already accepted

    logic              w_hit;
    logic [WORD_W-1:0] w_lane_word;
    logic              w_cmd_fire;
    logic              w_data_fire;
    logic              w_fill_en;
    logic              w_merge_en;
    logic [LINE_W-1:0] w_wdf_data;

    // Address bit 0 and the top nibble carry no information; a single-beat
    // BL8 return makes rd_data_end redundant with rd_data_valid.
    logic w_unused;
    assign w_unused = &{1'b0, wrap_Addr[31:28], wrap_Addr[0], app_rd_data_end};

    // ---------------------------------------------------------------- outputs
    assign wrap_busy    = (r_state != ST_IDLE);
    assign wrap_ready   = (r_state == ST_DONE);
    assign wrap_RD      = r_rd;

    assign app_addr     = ADDR_W'({r_tag, 3'b000});
    assign app_cmd      = (r_state == ST_RD_CMD) ? APP_CMD_READ : APP_CMD_WRITE;
    assign app_en       = ((r_state == ST_WR_ISSUE) && !r_cmd_done) ||
                          (r_state == ST_RD_CMD);
    assign app_wdf_wren = (r_state == ST_WR_ISSUE) && !r_data_done;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = wdf_mask(r_lane, r_l, r_u);
    assign app_wdf_data = w_wdf_data;

    // The write word is replicated into every lane; the mask picks the one
    // that actually lands in DDR.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_W / WORD_W; gi++) begin : g_wdata
            assign w_wdf_data[gi*WORD_W +: WORD_W] = r_wr;
        end
    endgenerate

    assign w_cmd_fire  = app_en && app_rdy;
    assign w_data_fire = app_wdf_wren && app_wdf_rdy;

    // ------------------------------------------------------------------ cache
    assign w_fill_en  = (r_state == ST_RD_WAIT) && app_rd_data_valid;
    assign w_merge_en = (r_state == ST_LOOKUP) && r_we && (r_l || r_u);

    sram_line_cache u_cache (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_tag        (r_tag),
        .i_lane       (r_lane),
        .i_fill_en    (w_fill_en),
        .i_fill_data  (app_rd_data),
        .i_merge_en   (w_merge_en),
        .i_merge_data (r_wr),
        .i_merge_be   ({r_u, r_l}),
        .o_hit        (w_hit),
        .o_lane_word  (w_lane_word)
    );

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_tag       <= '0;
            r_lane      <= '0;
            r_we        <= 1'b0;
            r_l         <= 1'b0;
            r_u         <= 1'b0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (i_calib_done) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (wrap_CS) begin
                        r_tag   <= wrap_Addr[27:4];
                        r_lane  <= wrap_Addr[3:1];
                        r_we    <= wrap_WE;
                        r_l     <= wrap_L;
                        r_u     <= wrap_U;
                        r_wr    <= wrap_WR;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_cmd_done  <= 1'b0;
                    r_data_done <= 1'b0;
                    if (!r_we) begin
                        if (w_hit) begin
                            r_rd    <= w_lane_word;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RD_CMD;
                        end
                    end else if (!r_l && !r_u) begin
                        // nothing enabled: complete without touching DDR
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE: begin
                    // command and data channels handshake independently;
                    // leave once both have been accepted
                    if (w_cmd_fire)  r_cmd_done  <= 1'b1;
                    if (w_data_fire) r_data_done <= 1'b1;
                    if ((r_cmd_done || w_cmd_fire) && (r_data_done || w_data_fire))
                        r_state <= ST_DONE;
                end
                ST_RD_CMD: begin
                    if (app_rdy) r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        r_rd    <= app_rd_data[{r_lane, 4'b0000} +: WORD_W];
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mig_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_mig_bridge
// Directed bench for sram_mig_bridge. The bench plays both the initiator and
// the MIG core. "Cycle N" is the clock period following edge N-1, where edge 0
// is the capture edge; outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_sram_mig_bridge;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_calib_done;
    logic [31:0]  wrap_Addr;
    logic         wrap_CS;
    logic         wrap_L;
    logic         wrap_U;
    logic         wrap_WE;
    logic [15:0]  wrap_WR;
    logic [15:0]  wrap_RD;
    logic         wrap_ready;
    logic         wrap_busy;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;

    int errors = 0;
    int checks = 0;
    int n_cmd   = 0;   // commands accepted by the MIG model
    int n_ready = 0;   // wrap_ready pulses seen

    logic [127:0] rline;

    always #5 clk = ~clk;

    sram_mig_bridge #(.ADDR_W(28)) dut (
        .clk               (clk),
        .i_rst             (i_rst),
        .i_calib_done      (i_calib_done),
        .wrap_Addr         (wrap_Addr),
        .wrap_CS           (wrap_CS),
        .wrap_L            (wrap_L),
        .wrap_U            (wrap_U),
        .wrap_WE           (wrap_WE),
        .wrap_WR           (wrap_WR),
        .wrap_RD           (wrap_RD),
        .wrap_ready        (wrap_ready),
        .wrap_busy         (wrap_busy),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end)
    );

    always @(posedge clk) begin
        if (app_en && app_rdy) n_cmd   <= n_cmd + 1;
        if (wrap_ready)        n_ready <= n_ready + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for the capture edge, then drop CS (returns in cycle 1).
    task automatic request(input logic [31:0] a, input logic we, input logic l,
                           input logic u, input logic [15:0] d);
        wrap_Addr = a; wrap_WE = we; wrap_L = l; wrap_U = u; wrap_WR = d;
        wrap_CS = 1'b1;
        tick();
        wrap_CS = 1'b0;
        wrap_WR = 16'h0000;
    endtask

    // Return one BL8 line to the bridge on the next edge.
    task automatic mig_return(input logic [127:0] line);
        app_rd_data = line; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        tick();
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        i_rst = 1'b1; i_calib_done = 1'b0;
        repeat (3) tick();
        checks++; if (wrap_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", wrap_busy); end
        checks++; if (wrap_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", wrap_ready); end
        checks++; if (wrap_RD !== 16'h0) begin errors++; $display("FAIL rst_rd: got %h want 0000", wrap_RD); end
        checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin errors++; $display("FAIL rst_strobes: en=%b wren=%b end=%b want 0 0 0", app_en, app_wdf_wren, app_wdf_end); end
        checks++; if (app_addr !== 28'h0 || app_cmd !== 3'b000) begin errors++; $display("FAIL rst_addr_cmd: addr=%h cmd=%b want 0 000", app_addr, app_cmd); end
        checks++; if (app_wdf_data !== 128'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", app_wdf_data); end
        checks++; if (app_wdf_mask !== 16'hFFFF) begin errors++; $display("FAIL rst_mask: got %h want ffff", app_wdf_mask); end
        i_rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (wrap_busy !== 1'b1 || app_en !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL calib_wait: %0d cycles not busy or app_en high, want 0", bad); end
        i_calib_done = 1'b1;
        tick();
        checks++; if (wrap_busy !== 1'b0) begin errors++; $display("FAIL calib_done_busy: got %b want 0", wrap_busy); end
        $display("reset/calibration sequence done");
    endtask

    task automatic test_write();
        logic [127:0] exp_data;
        int r0;
        exp_data = {8{16'h1234}};
        r0 = n_ready;
        request(32'h0000_0032, 1'b1, 1'b1, 1'b1, 16'h1234);
        checks++; if (wrap_busy !== 1'b1 || app_en !== 1'b0) begin errors++; $display("FAIL wr_c1: busy=%b en=%b want 1 0", wrap_busy, app_en); end
        tick();
        checks++; if (app_en !== 1'b1 || app_cmd !== 3'b000) begin errors++; $display("FAIL wr_cmd: en=%b cmd=%b want 1 000", app_en, app_cmd); end
        checks++; if (app_addr !== 28'h000_0018) begin errors++; $display("FAIL wr_addr: got %h want 0000018", app_addr); end
        checks++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin errors++; $display("FAIL wr_wren: wren=%b end=%b want 1 1", app_wdf_wren, app_wdf_end); end
        checks++; if (app_wdf_mask !== 16'hFFF3) begin errors++; $display("FAIL wr_mask: got %h want fff3", app_wdf_mask); end
        checks++; if (app_wdf_data[31:16] !== 16'h1234) begin errors++; $display("FAIL wr_lane1: got %h want 1234", app_wdf_data[31:16]); end
        checks++; if (app_wdf_data !== exp_data) begin errors++; $display("FAIL wr_data: got %h want %h", app_wdf_data, exp_data); end
        tick();
        checks++; if (wrap_ready !== 1'b1 || app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin errors++; $display("FAIL wr_ready: ready=%b en=%b wren=%b want 1 0 0", wrap_ready, app_en, app_wdf_wren); end
        tick();
        checks++; if (wrap_ready !== 1'b0 || wrap_busy !== 1'b0) begin errors++; $display("FAIL wr_after: ready=%b busy=%b want 0 0", wrap_ready, wrap_busy); end
        checks++; if (n_ready - r0 != 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", n_ready - r0); end
        $display("write addr=00000032 data=1234 LU=11 mask=%h", app_wdf_mask);
    endtask

    task automatic test_read_miss_hit();
        int c0;
        int r0;
        c0 = n_cmd;
        request(32'h0000_0032, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++; if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 28'h18) begin errors++; $display("FAIL rd_cmd: en=%b cmd=%b addr=%h want 1 001 0000018", app_en, app_cmd, app_addr); end
        tick();
        checks++; if (app_en !== 1'b0 || wrap_ready !== 1'b0) begin errors++; $display("FAIL rd_wait: en=%b ready=%b want 0 0", app_en, wrap_ready); end
        tick();
        mig_return(rline);
        checks++; if (wrap_ready !== 1'b1 || wrap_RD !== 16'hBEEF) begin errors++; $display("FAIL rd_miss: ready=%b rd=%h want 1 beef", wrap_ready, wrap_RD); end
        checks++; if (n_cmd - c0 != 1) begin errors++; $display("FAIL rd_miss_cmds: got %0d want 1", n_cmd - c0); end
        tick();
        checks++; if (wrap_ready !== 1'b0 || wrap_busy !== 1'b0 || wrap_RD !== 16'hBEEF) begin errors++; $display("FAIL rd_miss_after: ready=%b busy=%b rd=%h want 0 0 beef", wrap_ready, wrap_busy, wrap_RD); end
        $display("read miss addr=00000032 rd=%h", wrap_RD);

        // hit on lane 2 of the same line; ignored address bits set, CS held
        // high while busy must not start a second request
        c0 = n_cmd; r0 = n_ready;
        wrap_Addr = 32'hA000_0035; wrap_WE = 1'b0; wrap_CS = 1'b1;
        tick();
        checks++; if (wrap_ready !== 1'b0 || wrap_busy !== 1'b1) begin errors++; $display("FAIL hit_c1: ready=%b busy=%b want 0 1", wrap_ready, wrap_busy); end
        tick();
        checks++; if (wrap_ready !== 1'b1 || wrap_RD !== 16'hC0DE) begin errors++; $display("FAIL hit_c2: ready=%b rd=%h want 1 c0de", wrap_ready, wrap_RD); end
        wrap_CS = 1'b0;
        tick();
        checks++; if (wrap_ready !== 1'b0 || wrap_busy !== 1'b0) begin errors++; $display("FAIL hit_after: ready=%b busy=%b want 0 0", wrap_ready, wrap_busy); end
        checks++; if (n_cmd != c0 || n_ready - r0 != 1) begin errors++; $display("FAIL hit_counts: cmds=%0d pulses=%0d want 0 1", n_cmd - c0, n_ready - r0); end
        $display("read hit addr=00000034 rd=%h", wrap_RD);
    endtask

    task automatic test_byte_write_hit();
        int c0;
        request(32'h0000_0032, 1'b1, 1'b1, 1'b0, 16'hAA55);
        tick();
        checks++; if (app_wdf_mask !== 16'hFFFB || app_en !== 1'b1 || app_wdf_wren !== 1'b1) begin errors++; $display("FAIL bw_mask: mask=%h en=%b wren=%b want fffb 1 1", app_wdf_mask, app_en, app_wdf_wren); end
        tick();
        checks++; if (wrap_ready !== 1'b1 || wrap_RD !== 16'hC0DE) begin errors++; $display("FAIL bw_ready: ready=%b rd=%h want 1 c0de", wrap_ready, wrap_RD); end
        tick();
        $display("byte write addr=00000032 data=aa55 LU=10 done");
        c0 = n_cmd;
        request(32'h0000_0032, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++; if (wrap_ready !== 1'b1 || wrap_RD !== 16'hBE55) begin errors++; $display("FAIL bw_readback: ready=%b rd=%h want 1 be55", wrap_ready, wrap_RD); end
        checks++; if (n_cmd != c0) begin errors++; $display("FAIL bw_readback_cmds: got %0d want 0", n_cmd - c0); end
        tick();
        $display("read hit addr=00000032 rd=%h", wrap_RD);
        // no byte enables: completes in cycle 2 without any DDR traffic
        request(32'h0000_0040, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        tick();
        checks++; if (wrap_ready !== 1'b1 || app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin errors++; $display("FAIL null_write: ready=%b en=%b wren=%b want 1 0 0", wrap_ready, app_en, app_wdf_wren); end
        checks++; if (n_cmd != c0) begin errors++; $display("FAIL null_write_cmds: got %0d want 0", n_cmd - c0); end
        tick();
        $display("null write addr=00000040 done");
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_data;
        int bad;
        exp_data = {8{16'h5678}};
        bad = 0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        request(32'h0000_0100, 1'b1, 1'b1, 1'b1, 16'h5678);
        tick();
        // cycles 2..10: command accepted at end of cycle 7, data at end of 10
        for (int c = 2; c <= 10; c++) begin
            app_rdy     = (c == 7);
            app_wdf_rdy = (c == 10);
            if (app_en !== (c <= 7)) bad++;
            if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) bad++;
            if (app_addr !== 28'h80 || app_cmd !== 3'b000) bad++;
            if (app_wdf_mask !== 16'hFFFC || app_wdf_data !== exp_data) bad++;
            if (wrap_ready !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad samples want 0", bad); end
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        checks++; if (wrap_ready !== 1'b1 || app_wdf_wren !== 1'b0) begin errors++; $display("FAIL bp_ready: ready=%b wren=%b want 1 0", wrap_ready, app_wdf_wren); end
        tick();
        checks++; if (wrap_ready !== 1'b0 || wrap_busy !== 1'b0) begin errors++; $display("FAIL bp_after: ready=%b busy=%b want 0 0", wrap_ready, wrap_busy); end
        $display("backpressured write addr=00000100 data=5678 done");
    endtask

    task automatic test_reset_mid_read();
        int r0;
        request(32'h0000_0200, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        r0 = n_ready;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (wrap_busy !== 1'b1 || app_en !== 1'b0 || wrap_RD !== 16'h0) begin errors++; $display("FAIL midrst_state: busy=%b en=%b rd=%h want 1 0 0000", wrap_busy, app_en, wrap_RD); end
        mig_return(rline);   // arrives while in INIT
        mig_return(rline);   // arrives while in IDLE
        tick();
        tick();
        checks++; if (n_ready != r0 || wrap_busy !== 1'b0) begin errors++; $display("FAIL midrst_stale: pulses=%0d busy=%b want 0 0", n_ready - r0, wrap_busy); end
        $display("reset during read wait, stale returns dropped");
        // 0x32 was cached before reset; must now miss
        request(32'h0000_0032, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++; if (app_en !== 1'b1 || wrap_ready !== 1'b0) begin errors++; $display("FAIL midrst_miss: en=%b ready=%b want 1 0", app_en, wrap_ready); end
        tick();
        mig_return(rline);
        checks++; if (wrap_ready !== 1'b1 || wrap_RD !== 16'hBEEF) begin errors++; $display("FAIL midrst_reread: ready=%b rd=%h want 1 beef", wrap_ready, wrap_RD); end
        tick();
        $display("read miss after reset addr=00000032 rd=%h", wrap_RD);
    endtask

    initial begin
        i_rst = 1'b1; i_calib_done = 1'b0;
        wrap_Addr = 32'h0; wrap_CS = 1'b0; wrap_L = 1'b0; wrap_U = 1'b0;
        wrap_WE = 1'b0; wrap_WR = 16'h0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data = 128'h0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        rline = {16'h7007, 16'h6006, 16'h5005, 16'h4004,
                 16'h3003, 16'hC0DE, 16'hBEEF, 16'h1001};

        test_reset();
        test_write();
        test_read_miss_hit();
        test_byte_write_hit();
        test_backpressure();
        test_reset_mid_read();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
